fifo_access_ctrl: RTL

- Controller that shares one 8-bit fifo between NUM_REQ producers.
- Producer side: round-robin arbitration drives the fifo push port.
- Consumer side: sequences fifo pops and presents each word on a valid/ready output register.
- Tracks fifo occupancy in a level counter. Sits directly in front of and behind the fifo instance; the fifo shares clk and reset with this block.

---
 rtl/fifo_ctrl_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/fifo_access_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the fifo access controller: pop sequencer states and
// default datapath sizing.
package fifo_ctrl_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } pop_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// i_ptr (wrapping) and returns the one-hot grant, its index and the next pointer.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [PTR_W-1:0]   o_idx,
   output logic [PTR_W-1:0]   o_next_ptr
);

   logic w_found;
   int   w_cand;

   always_comb begin
      o_grant    = '0;
      o_idx      = '0;
      o_next_ptr = i_ptr;
      w_found    = 1'b0;
      w_cand     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = (int'(i_ptr) + k) % NUM_REQ;
         if (i_en && !w_found && i_req[w_cand]) begin
            w_found          = 1'b1;
            o_grant[w_cand]  = 1'b1;
            o_idx            = PTR_W'(w_cand);
            o_next_ptr       = PTR_W'((w_cand + 1) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Shares one fifo between NUM_REQ producers (round-robin push side) and a single
// valid/ready consumer (pop sequencer), tracking fifo occupancy in a level counter.
//
// state | meaning
// IDLE  | no word held; pop as soon as the fifo is non-empty
// FETCH | fifo read data is valid this cycle; capture it into rd_data
// HOLD  | rd_data presented with rd_valid=1 until rd_ready
module fifo_access_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int LVL_W   = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      fifo_push,
   output logic [DATA_W-1:0]         fifo_data_in,
   input  logic                      fifo_full,
   input  logic                      fifo_empty,
   output logic                      fifo_pop,
   input  logic [DATA_W-1:0]         fifo_data_out,
   output logic                      rd_valid,
   output logic [DATA_W-1:0]         rd_data,
   input  logic                      rd_ready,
   output logic [LVL_W-1:0]          level
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   w_next_ptr;
   logic [PTR_W-1:0]   w_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_arb_en;

   pop_state_t         r_state;
   pop_state_t         w_state_nxt;
   logic               w_pop;

   logic               r_rd_valid;
   logic [DATA_W-1:0]  r_rd_data;
   logic [LVL_W-1:0]   r_level;

   // Full fifo and reset both suppress any grant; the pointer then holds.
   assign w_arb_en = !reset && !fifo_full;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .i_req      (req),
      .i_ptr      (r_ptr),
      .i_en       (w_arb_en),
      .o_grant    (w_grant),
      .o_idx      (w_idx),
      .o_next_ptr (w_next_ptr)
   );

   assign grant     = w_grant;
   assign fifo_push = |w_grant;

   always_comb begin
      fifo_data_in = '0;
      if (fifo_push) begin
         fifo_data_in = req_data[int'(w_idx)*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (fifo_push) begin
         r_ptr <= w_next_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            w_state_nxt = HOLD;
         end
         HOLD: begin
            if (rd_ready) begin
               if (!fifo_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = FETCH;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign fifo_pop = w_pop && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else if (r_state == FETCH) begin
         r_rd_valid <= 1'b1;
         r_rd_data  <= fifo_data_out;
      end else if (r_state == HOLD && rd_ready) begin
         r_rd_valid <= 1'b0;
      end
   end

   // Push is gated by full and pop by empty, so the counter cannot wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_level <= '0;
      end else begin
         r_level <= r_level + LVL_W'(fifo_push) - LVL_W'(fifo_pop);
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign level    = r_level;

endmodule
